// File: rtl/ea_index_unit_if.sv
// Handshake/bus bundle between the 6502 sequencer and the effective-address indexing stage.
// Ports: start/mode/base_l/base_h/index flow sequencer -> unit;
//        addr_l/addr_h/load_l/load_h/h_inc/busy/done/page_cross/extra_cycle flow unit -> sequencer/register.
interface ea_index_unit_if;
  logic       start;
  logic [1:0] mode;
  logic [7:0] base_l;
  logic [7:0] base_h;
  logic [7:0] index;
  logic [7:0] addr_l;
  logic [7:0] addr_h;
  logic       load_l;
  logic       load_h;
  logic       h_inc;
  logic       busy;
  logic       done;
  logic       page_cross;
  logic       extra_cycle;

  // Sequencer side: issues requests, observes results.
  modport master (
    output start, mode, base_l, base_h, index,
    input  addr_l, addr_h, load_l, load_h, h_inc, busy, done, page_cross, extra_cycle
  );

  // Indexing unit side.
  modport slave (
    input  start, mode, base_l, base_h, index,
    output addr_l, addr_h, load_l, load_h, h_inc, busy, done, page_cross, extra_cycle
  );
endinterface

// File: rtl/ea_index_unit.sv
// Effective-address indexing: base + 8-bit index loaded into the D/T address register, with high-byte fix-up on carry.
// Latency: done 1 cycle after accept (no fix-up) or 2 cycles (fix-up / forced extra cycle in mode 01).
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored while busy.
// Ports: clk, rst (async, active-high), eif (slave modport): start/mode/base_l/base_h/index in;
//        addr_l/addr_h + load_l/load_h/h_inc strobes to the register, busy/done/page_cross/extra_cycle status out.
module ea_index_unit (
  input  logic          clk,
  input  logic          rst,
  ea_index_unit_if.slave eif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ABS_X     = 2'b00;
  localparam logic [1:0] MODE_ABS_X_STR = 2'b01;
  localparam logic [1:0] MODE_ZP_X      = 2'b10;
  localparam logic [1:0] MODE_ABS       = 2'b11;

  state_t     state;
  logic [1:0] mode_q;
  logic [8:0] sum9_q;
  logic [7:0] base_h_q;
  logic       page_cross_q;
  logic       extra_cycle_q;

  logic       accept;
  logic [7:0] index_eff;
  logic [8:0] sum9_d;
  logic       carry;

  assign accept    = eif.start && ((state == S_IDLE) || (state == S_DONE));
  // Unindexed absolute addressing ignores whatever sits on the index bus.
  assign index_eff = (eif.mode == MODE_ABS) ? 8'h00 : eif.index;
  assign sum9_d    = {1'b0, eif.base_l} + {1'b0, index_eff};
  // Zero-page indexing wraps inside page 0, so its carry is discarded (mode[1] covers modes 10 and 11).
  assign carry     = sum9_q[8] & ~mode_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= MODE_ABS_X;
      sum9_q        <= 9'd0;
      base_h_q      <= 8'h00;
      page_cross_q  <= 1'b0;
      extra_cycle_q <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE and the back-to-back case from DONE.
      mode_q        <= eif.mode;
      sum9_q        <= sum9_d;
      base_h_q      <= eif.base_h;
      page_cross_q  <= 1'b0;
      extra_cycle_q <= 1'b0;
      state         <= S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          page_cross_q <= carry;
          // Stores/RMW always spend the extra cycle so bus timing does not depend on the data.
          state        <= (carry || (mode_q == MODE_ABS_X_STR)) ? S_FIX : S_DONE;
        end
        S_FIX: begin
          extra_cycle_q <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address bytes come straight from the latched operands: stable through LOAD, zero after reset.
  assign eif.addr_l      = sum9_q[7:0];
  assign eif.addr_h      = (mode_q == MODE_ZP_X) ? 8'h00 : base_h_q;
  // Strobes are decoded from state so an async reset kills them immediately.
  assign eif.load_l      = (state == S_LOAD);
  assign eif.load_h      = (state == S_LOAD);
  assign eif.h_inc       = (state == S_FIX) && carry;
  assign eif.busy        = (state == S_LOAD) || (state == S_FIX);
  assign eif.done        = (state == S_DONE);
  assign eif.page_cross  = page_cross_q;
  assign eif.extra_cycle = extra_cycle_q;

endmodule

// File: tb/tb_ea_index_unit.sv
module tb_ea_index_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ea_index_unit_if eif ();

  ea_index_unit dut (
    .clk (clk),
    .rst (rst),
    .eif (eif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream 16-bit address register driven by the unit's strobes.
  logic [15:0] reg_q;
  always @(posedge clk) begin
    if (eif.load_l) reg_q[7:0] <= eif.addr_l;
    if (eif.load_h) reg_q[15:8] <= eif.addr_h;
    if (eif.h_inc)  reg_q[15:8] <= reg_q[15:8] + 8'd1;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  base_l;
    logic [7:0]  base_h;
    logic [7:0]  index;
    logic [7:0]  exp_l;
    logic [7:0]  exp_h;
    logic        exp_fix;
    logic        exp_hinc;
    logic        exp_pc;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " load_l"}, {15'd0, eif.load_l}, 16'd0);
    chk({tag, " load_h"}, {15'd0, eif.load_h}, 16'd0);
    chk({tag, " h_inc"},  {15'd0, eif.h_inc},  16'd0);
    chk({tag, " busy"},   {15'd0, eif.busy},   16'd0);
    chk({tag, " done"},   {15'd0, eif.done},   16'd0);
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic [15:0] base, input logic [7:0] idx);
    eif.start  = s;
    eif.mode   = m;
    eif.base_l = base[7:0];
    eif.base_h = base[15:8];
    eif.index  = idx;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    string t;
    t = $sformatf("v%0d", n);
    @(negedge clk);
    drive(1'b1, v.mode, {v.base_h, v.base_l}, v.index);
    @(negedge clk);                       // E0 passed: LOAD
    eif.start = 1'b0;
    chk({t, " load addr_l"}, {8'h00, eif.addr_l}, {8'h00, v.exp_l});
    chk({t, " load addr_h"}, {8'h00, eif.addr_h}, {8'h00, v.exp_h});
    chk({t, " load strobes"}, {13'd0, eif.load_l, eif.load_h, eif.h_inc}, 16'b110);
    chk({t, " load busy/done"}, {14'd0, eif.busy, eif.done}, 16'b10);
    @(negedge clk);                       // E1 passed
    chk({t, " page_cross"}, {15'd0, eif.page_cross}, {15'd0, v.exp_pc});
    if (v.exp_fix) begin
      chk({t, " fix strobes"}, {13'd0, eif.load_l, eif.load_h, eif.h_inc}, {13'd0, 2'b00, v.exp_hinc});
      chk({t, " fix busy/done"}, {14'd0, eif.busy, eif.done}, 16'b10);
      chk({t, " fix extra_cycle"}, {15'd0, eif.extra_cycle}, 16'd0);
      @(negedge clk);                     // E2 passed
    end
    chk({t, " done"}, {14'd0, eif.busy, eif.done}, 16'b01);
    chk({t, " extra_cycle"}, {15'd0, eif.extra_cycle}, {15'd0, v.exp_fix});
    chk({t, " register"}, reg_q, v.exp_reg);
    @(negedge clk);
    chk_idle({t, " after"});
    chk({t, " pc held"}, {15'd0, eif.page_cross}, {15'd0, v.exp_pc});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //            mode   bl     bh     idx    exp_l  exp_h  fix   hinc  pc    reg
    vecs[0] = '{2'b00, 8'hF0, 8'h12, 8'h0F, 8'hFF, 8'h12, 1'b0, 1'b0, 1'b0, 16'h12FF};
    vecs[1] = '{2'b00, 8'hF0, 8'h12, 8'h20, 8'h10, 8'h12, 1'b1, 1'b1, 1'b1, 16'h1310};
    vecs[2] = '{2'b01, 8'h00, 8'h40, 8'h05, 8'h05, 8'h40, 1'b1, 1'b0, 1'b0, 16'h4005};
    vecs[3] = '{2'b10, 8'hFF, 8'h99, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0001};
    vecs[4] = '{2'b11, 8'hCD, 8'hAB, 8'h77, 8'hCD, 8'hAB, 1'b0, 1'b0, 1'b0, 16'hABCD};
    vecs[5] = '{2'b01, 8'hF0, 8'h40, 8'h20, 8'h10, 8'h40, 1'b1, 1'b1, 1'b1, 16'h4110};
    vecs[6] = '{2'b10, 8'h80, 8'h55, 8'h90, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0010};
    vecs[7] = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h00FE};

    rst = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 8'h00);
    #12;
    chk("reset addr_l", {8'h00, eif.addr_l}, 16'h0000);
    chk("reset addr_h", {8'h00, eif.addr_h}, 16'h0000);
    chk("reset flags", {14'd0, eif.page_cross, eif.extra_cycle}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i));
    end

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-to-back: start held high; operand change during LOAD must be ignored.
    @(negedge clk);
    drive(1'b1, 2'b00, 16'h1000, 8'h01);
    @(negedge clk);                       // LOAD of A
    drive(1'b1, 2'b00, 16'h2030, 8'h04);
    chk("b2b A addr_l", {8'h00, eif.addr_l}, 16'h0001);
    chk("b2b A addr_h", {8'h00, eif.addr_h}, 16'h0010);
    @(negedge clk);                       // DONE of A, start still high
    chk("b2b A done", {14'd0, eif.busy, eif.done}, 16'b01);
    chk("b2b A reg", reg_q, 16'h1001);
    @(negedge clk);                       // LOAD of B, no bubble
    eif.start = 1'b0;
    chk("b2b B load", {14'd0, eif.load_l, eif.load_h}, 16'b11);
    chk("b2b B addr", {eif.addr_h, eif.addr_l}, 16'h2034);
    @(negedge clk);
    chk("b2b B done", {15'd0, eif.done}, 16'd1);
    chk("b2b B reg", reg_q, 16'h2034);

    // start pulse during FIX is ignored.
    @(negedge clk);
    drive(1'b1, 2'b00, 16'h30C0, 8'h50);
    @(negedge clk);                       // LOAD
    eif.start = 1'b0;
    @(negedge clk);                       // FIX
    chk("fixpulse h_inc", {15'd0, eif.h_inc}, 16'd1);
    drive(1'b1, 2'b11, 16'h7777, 8'h00);
    @(negedge clk);                       // DONE
    eif.start = 1'b0;
    chk("fixpulse done", {14'd0, eif.busy, eif.done}, 16'b01);
    chk("fixpulse reg", reg_q, 16'h3110);
    chk("fixpulse addr", {eif.addr_h, eif.addr_l}, 16'h3010);
    @(negedge clk);
    chk_idle("fixpulse after");

    // Async reset mid-FIX.
    drive(1'b1, 2'b00, 16'h50F8, 8'h10);
    @(negedge clk);                       // LOAD
    eif.start = 1'b0;
    @(negedge clk);                       // FIX
    chk("arst pre h_inc", {15'd0, eif.h_inc}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst h_inc", {15'd0, eif.h_inc}, 16'd0);
    chk("arst busy", {15'd0, eif.busy}, 16'd0);
    chk("arst flags", {14'd0, eif.page_cross, eif.extra_cycle}, 16'd0);
    chk("arst addr", {eif.addr_h, eif.addr_l}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("arst after");

    // Accept right after reset still works.
    run_vec(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
